// File: rtl/uart_pkg.sv
// Shared UART definitions for the word loader link (transmit and receive sides).
// Optional even-parity framing is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    localparam int CLK_HZ                = 50_000_000;
    localparam int BAUD_RATE             = 9600;
    localparam int CLKS_PER_BIT_DEFAULT  = CLK_HZ / BAUD_RATE;
    localparam int BYTE_GAP_CLKS_DEFAULT = 5;
    localparam int FIFO_DEPTH_DEFAULT    = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
`ifdef UART_TX_PARITY_EN
        ,
        ST_PARITY = 3'd6
`endif
    } tx_state_e;

    function automatic logic even_parity(input logic [7:0] data_byte);
        return ^data_byte;
    endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Small first-word-fall-through synchronous FIFO with active-low synchronous reset.
// Also exposes the post-edge count so the parent can register flags without extra latency.
module uart_word_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_next
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/uart_word_tx.sv
// UART word transmitter: buffers 16-bit words and sends each as two bytes, LSB byte first.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits (11-bit frame).
module uart_word_tx
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT  = CLKS_PER_BIT_DEFAULT,
    parameter  int BYTE_GAP_CLKS = BYTE_GAP_CLKS_DEFAULT,
    parameter  int FIFO_DEPTH    = FIFO_DEPTH_DEFAULT,
    localparam int CNT_W         = $clog2(CLKS_PER_BIT),
    localparam int FCNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              word_valid,
    input  logic [15:0]       word_data,
    output logic              word_ready,
    output logic              uart_tx_pin,
    output logic              busy,
    output logic [FCNT_W-1:0] fifo_count
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BYTE_GAP_CLKS - 1);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [15:0]       shift_q, shift_d;
    logic              hi_byte_q, hi_byte_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [15:0]       fifo_head;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count_d;
    logic              baud_wrap;

    assign fifo_push = word_valid && ready_q;
    assign baud_wrap = (baud_cnt_q == BIT_LAST);

    uart_word_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RESET),
        .push       (fifo_push),
        .push_data  (word_data),
        .pop        (fifo_pop),
        .head_data  (fifo_head),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .count_next (fifo_count_d)
    );

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        hi_byte_d  = hi_byte_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                hi_byte_d  = 1'b0;
                state_d    = ST_START;
            end
            ST_START: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    state_d    = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_wrap) begin
                    baud_cnt_d = '0;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (baud_cnt_q == GAP_LAST) begin
                    baud_cnt_d = '0;
                    if (!hi_byte_q) begin
                        // Shift the MSB byte down so the data path always reads bits [7:0].
                        hi_byte_d = 1'b1;
                        shift_d   = {8'h00, shift_q[15:8]};
                        bit_idx_d = '0;
                        state_d   = ST_START;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = ST_IDLE;
            end
        endcase

        // The line is registered from the next state so it changes on the state-entry edge.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = even_parity(shift_d[7:0]);
`endif
            default:   tx_d = 1'b1;
        endcase

        busy_d  = (state_d != ST_IDLE) || (fifo_count_d != '0);
        ready_d = (fifo_count_d != FCNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            hi_byte_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            hi_byte_q  <= hi_byte_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign uart_tx_pin = tx_q;
    assign busy        = busy_q;
    assign word_ready  = ready_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed self-checking bench for uart_word_tx using a shortened bit period.
// A line monitor decodes frames so byte values and start-bit timing can be compared.
module tb_uart_word_tx;

    localparam int C     = 8;
    localparam int G     = 5;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int BYTE_T = FB * C + G;
    localparam int WORD_T = 2 * BYTE_T;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        word_valid = 1'b0;
    logic [15:0] word_data = 16'h0000;
    logic        word_ready;
    logic        uart_tx_pin;
    logic        busy;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [7:0] rx_bytes [$];
    int         rx_start [$];
    logic       rx_par   [$];
    logic       rx_stop  [$];

    uart_word_tx #(
        .CLKS_PER_BIT  (C),
        .BYTE_GAP_CLKS (G),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_ready  (word_ready),
        .uart_tx_pin (uart_tx_pin),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns the cycle number of the accepting rising edge.
    task automatic push(input logic [15:0] w, output int acc);
        int t;
        t = 0;
        word_valid = 1'b1;
        word_data  = w;
        while (!word_ready && t < 5000) begin
            @(negedge CLK);
            t++;
        end
        check("push_ready", word_ready, 1'b1);
        acc = cyc + 1;
        @(negedge CLK);
        word_valid = 1'b0;
        word_data  = 16'hxxxx;
        $display("push %04h accepted at cycle %0d", w, acc);
    endtask

    task automatic wait_bytes(input int n);
        int t;
        t = 0;
        while (rx_bytes.size() < n && t < 4000) begin
            @(negedge CLK);
            t++;
        end
        check("rx_count", rx_bytes.size(), n);
    endtask

    task automatic wait_idle(output int fall);
        int t;
        t = 0;
        while (busy && t < 4000) begin
            @(negedge CLK);
            t++;
        end
        fall = cyc;
        check("idle_reached", busy, 1'b0);
    endtask

    task automatic clear_rx();
        rx_bytes.delete();
        rx_start.delete();
        rx_par.delete();
        rx_stop.delete();
    endtask

    // Line monitor: samples each bit in the middle of its period.
    initial begin : monitor
        logic       prev;
        logic [7:0] b;
        logic       p;
        logic       stp;
        int         sc;
        prev = 1'b1;
        forever begin
            @(negedge CLK);
            if (prev && !uart_tx_pin && RESET) begin
                sc = cyc;
                repeat (C / 2) @(negedge CLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge CLK);
                    b[i] = uart_tx_pin;
                end
`ifdef UART_TX_PARITY_EN
                repeat (C) @(negedge CLK);
                p = uart_tx_pin;
`else
                p = 1'b0;
`endif
                repeat (C) @(negedge CLK);
                stp = uart_tx_pin;
                rx_bytes.push_back(b);
                rx_start.push_back(sc);
                rx_par.push_back(p);
                rx_stop.push_back(stp);
                $display("rx byte %02h start %0d parity %0b stop %0b", b, sc, p, stp);
            end
            prev = uart_tx_pin;
        end
    end

    initial begin : stim
        int acc;
        int fall;
        logic [7:0] exp_b;

        // 1: reset held for three edges, then the first released edge raises word_ready.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_line", uart_tx_pin, 1'b1);
        check("rst_ready", word_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        RESET = 1'b1;
        @(negedge CLK);
        check("ready_after_rst", word_ready, 1'b1);
        check("line_idle", uart_tx_pin, 1'b1);
        repeat (3) @(negedge CLK);

        // 2: single word, latency, byte order, busy length.
        push(16'hA55A, acc);
        check("count_after_push", fifo_count, 3'd1);
        check("busy_after_push", busy, 1'b1);
        @(negedge CLK);
        check("count_after_pop", fifo_count, 3'd0);
        wait_idle(fall);
        check("busy_fall_cycle", fall, acc + 2 + WORD_T);
        wait_bytes(2);
        if (rx_bytes.size() >= 2) begin
            check("a55a_start_cycle", rx_start[0], acc + 2);
            check("a55a_lsb", rx_bytes[0], 8'h5A);
            check("a55a_msb", rx_bytes[1], 8'hA5);
            check("a55a_byte_gap", rx_start[1] - rx_start[0], BYTE_T);
            check("a55a_stop", {rx_stop[0], rx_stop[1]}, 2'b11);
        end
        clear_rx();
        repeat (4) @(negedge CLK);

        // 3: five back-to-back words; FIFO fills behind the word in flight.
        for (int k = 1; k <= 5; k++) begin
            push(16'(k), acc);
        end
        check("full_ready_low", word_ready, 1'b0);
        check("full_count", fifo_count, 3'd4);
        wait_bytes(10);
        if (rx_bytes.size() >= 10) begin
            for (int k = 0; k < 10; k++) begin
                exp_b = (k % 2 == 0) ? 8'(k / 2 + 1) : 8'h00;
                check($sformatf("b2b_byte%0d", k), rx_bytes[k], exp_b);
                check($sformatf("b2b_stop%0d", k), rx_stop[k], 1'b1);
                if (k > 0) begin
                    check($sformatf("b2b_spacing%0d", k), rx_start[k] - rx_start[k-1],
                          (k % 2 == 1) ? BYTE_T : BYTE_T + 1);
                end
            end
        end
        wait_idle(fall);
        check("b2b_count_empty", fifo_count, 3'd0);
        clear_rx();
        repeat (4) @(negedge CLK);

        // 4: reset in the middle of the data bits aborts the frame and flushes state.
        push(16'h00FF, acc);
        push(16'hBEEF, acc);
        repeat (4 * C) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("midrst_line", uart_tx_pin, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", word_ready, 1'b0);
        check("midrst_count", fifo_count, 3'd0);
        RESET = 1'b1;
        @(negedge CLK);
        check("midrst_ready_back", word_ready, 1'b1);
        repeat (12 * C) @(negedge CLK);
        check("midrst_stays_idle", busy, 1'b0);
        clear_rx();
        push(16'h1234, acc);
        wait_idle(fall);
        check("post_rst_fall", fall, acc + 2 + WORD_T);
        wait_bytes(2);
        if (rx_bytes.size() >= 2) begin
            check("post_rst_start", rx_start[0], acc + 2);
            check("post_rst_lsb", rx_bytes[0], 8'h34);
            check("post_rst_msb", rx_bytes[1], 8'h12);
        end
        clear_rx();
        repeat (4) @(negedge CLK);

        // 5: 0x0307, whose two bytes have opposite parity.
        push(16'h0307, acc);
        wait_idle(fall);
        check("w0307_word_time", fall - (acc + 2), WORD_T);
        wait_bytes(2);
        if (rx_bytes.size() >= 2) begin
            check("w0307_lsb", rx_bytes[0], 8'h07);
            check("w0307_msb", rx_bytes[1], 8'h03);
`ifdef UART_TX_PARITY_EN
            check("w0307_par_lsb", rx_par[0], 1'b1);
            check("w0307_par_msb", rx_par[1], 1'b0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
